snn_uart_frame_ctrl: RTL
========================

Name: snn_uart_frame_ctrl

Overview:
- SNN-side endpoint of the host image-transfer protocol.
- Receives the 98 image bytes from uart_rx and unpacks them LSB-first into 784 single-bit pixel writes to the image RAM.
- Signals the classifier when the frame is complete, then returns the classified digit to the host through uart_tx as one byte.
- Sits between uart_rx/uart_tx and the snn classifier core inside snn.

Parameters:
- NUM_BYTES, 98, bytes per frame.
- ADDR_WIDTH, 10, image RAM address width; must satisfy 2^ADDR_WIDTH >= NUM_BYTES*8.
- ASCII_OUT, 0, 0 = send digit as 8'h00-8'h09; 1 = send 8'h30 + digit.

Ports:
- clk  in  1  system clock; the block uses one clock.
- rst  in  1  reset; synchronous and active-high.
- rx_rdy  in  1  uart_rx byte-valid level; a byte is taken on its rising edge.
- rx_data  in  8  uart_rx received byte.
- img_we  out  1  image RAM write enable.
- img_addr  out  ADDR_WIDTH  pixel address, 0..NUM_BYTES*8-1.
- img_wdata  out  1  pixel bit.
- img_ready  out  1  one-cycle pulse when the full frame has been written.
- result_valid  in  1  classifier result strobe.
- result_digit  in  4  classified digit, 0..9.
- tx_rdy  in  1  uart_tx idle.
- tx_start  out  1  one-cycle uart_tx start pulse.
- tx_data  out  8  byte to transmit; held stable until the next send.
- rx_overrun  out  1  sticky; set when a byte arrives outside LOAD. Cleared only by rst.

Behaviour:
- Reset (rst=1 at posedge clk):
  - state=LOAD, byte_cnt=0.
  - img_we=0, img_addr=0, img_wdata=0, img_ready=0.
  - tx_start=0, tx_data=8'h00, rx_overrun=0.
  - Edge-detect register loads current rx_rdy, so a level high during reset is not a new byte.
  - Reset mid-frame discards the partial frame.
- rx_rdy edge: rx_rdy registered each cycle. A new byte is rx_rdy=1 while the previous sample was 0.
- LOAD:
  - On a new byte: latch rx_data into shift register, bit_cnt=0, go to UNPACK.
- UNPACK (exactly 8 cycles per byte):
  - Cycle i (i=0..7): img_we=1, img_addr=byte_cnt*8+i, img_wdata=byte[i] (LSB first).
  - After i=7: byte_cnt increments.
  - If byte_cnt becomes NUM_BYTES: pulse img_ready=1 for one cycle and go to WAIT_RES. Otherwise return to LOAD.
  - img_we=0 in every other state.
- WAIT_RES:
  - On result_valid=1: latch tx_data = result_digit (ASCII_OUT=0) or 8'h30+result_digit (ASCII_OUT=1), then go to SEND.
  - result_digit>9 is sent unmodified; no saturation.
- SEND:
  - When tx_rdy=1: assert tx_start for exactly one cycle, reset byte_cnt=0, go to LOAD.
  - While tx_rdy=0: wait; no timeout.
- Overrun: a new byte in UNPACK, WAIT_RES or SEND is dropped and sets rx_overrun. Frame state is unaffected.
- Ignored inputs: result_valid outside WAIT_RES. tx_rdy outside SEND.
- Simultaneous result_valid and new byte in WAIT_RES: the result is taken, the byte is dropped, rx_overrun is set.
- Latency:
  - Byte edge to first img_we: 1 cycle.
  - Last img_we to img_ready: same cycle as the i=7 write, registered.
  - result_valid to tx_start: 1 cycle if tx_rdy is already high.

Test Plan:
- Reset, send byte 8'hA5 -> 8 writes at addr 0..7, data 1,0,1,0,0,1,0,1. img_ready stays 0. byte_cnt=1.
- Send 98 bytes 8'h00..8'h61 -> 784 writes total. Last write addr 783 carries bit7 of 8'h61 = 0. Exactly one img_ready pulse, with the addr-783 write.
- After frame, result_valid with digit 7, tx_rdy=1 -> tx_start pulse next cycle, tx_data=8'h07. Repeat with ASCII_OUT=1 -> tx_data=8'h37.
- Hold tx_rdy=0 for 50 cycles after result -> no tx_start. Raise tx_rdy -> single tx_start. A following byte then writes addr 0..7 (new frame).
- Byte edge during WAIT_RES -> no img_we, rx_overrun=1 and stays 1 through a full subsequent frame. rst clears it.
- Assert rst after 40 bytes, then send 98 bytes -> writes restart at addr 0 and img_ready fires after the 98th byte, not the 58th.

Source files
------------

// File: rtl/snn_uart_frame_ctrl.sv
// snn_uart_frame_ctrl: unpacks a 98-byte uart image frame into 1-bit pixel writes, then returns the classified digit over uart.
module snn_uart_frame_ctrl #(
  parameter int NUM_BYTES  = 98,
  parameter int ADDR_WIDTH = 10,
  parameter bit ASCII_OUT  = 1'b0
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  rx_rdy,
  input  logic [7:0]            rx_data,
  output logic                  img_we,
  output logic [ADDR_WIDTH-1:0] img_addr,
  output logic                  img_wdata,
  output logic                  img_ready,
  input  logic                  result_valid,
  input  logic [3:0]            result_digit,
  input  logic                  tx_rdy,
  output logic                  tx_start,
  output logic [7:0]            tx_data,
  output logic                  rx_overrun
);
  typedef enum logic [1:0] {LOAD, UNPACK, WAIT_RES, SEND} state_t;
  localparam logic [ADDR_WIDTH-4:0] LAST_BYTE = (ADDR_WIDTH-3)'(NUM_BYTES - 1);
  state_t state, next;
  logic rx_q, new_byte, last_bit, frame_done;
  logic [7:0] shreg;
  logic [2:0] bit_cnt;
  logic [ADDR_WIDTH-4:0] byte_cnt;
  assign new_byte   = rx_rdy & ~rx_q;
  assign last_bit   = bit_cnt == 3'd7;
  assign frame_done = last_bit && byte_cnt == LAST_BYTE;
  always_ff @(posedge clk) state <= rst ? LOAD : next;
  always_comb begin
    next = state;
    case (state)
      LOAD:     next = new_byte ? UNPACK : LOAD;
      UNPACK:   next = last_bit ? (frame_done ? WAIT_RES : LOAD) : UNPACK;
      WAIT_RES: next = result_valid ? SEND : WAIT_RES;
      SEND:     next = tx_rdy ? LOAD : SEND;
      default:  next = LOAD;
    endcase
  end
  // pixel address is simply {byte index, bit index}, so writes land LSB first
  always_comb begin
    img_we    = state == UNPACK;
    img_addr  = img_we ? {byte_cnt, bit_cnt} : '0;
    img_wdata = img_we & shreg[bit_cnt];
    img_ready = img_we & frame_done;
    tx_start  = state == SEND && tx_rdy;
  end
  always_ff @(posedge clk) begin
    rx_q <= rx_rdy;
    if (rst) begin
      shreg      <= '0;
      bit_cnt    <= '0;
      byte_cnt   <= '0;
      tx_data    <= '0;
      rx_overrun <= 1'b0;
    end else begin
      if (state == LOAD && new_byte) begin
        shreg   <= rx_data;
        bit_cnt <= '0;
      end
      if (state == UNPACK) begin
        bit_cnt <= bit_cnt + 3'd1;
        if (last_bit) byte_cnt <= byte_cnt + 1'b1;
      end
      if (state == WAIT_RES && result_valid)
        tx_data <= ASCII_OUT ? 8'h30 + {4'h0, result_digit} : {4'h0, result_digit};
      if (tx_start) byte_cnt <= '0;
      if (new_byte && state != LOAD) rx_overrun <= 1'b1;
    end
  end
endmodule
